q3_sched: RTL and testbench
===========================

# q3_sched

Round-robin scheduler that shares one 8-bit XOR/add datapath among `NUM_REQ` requesters. The datapath has a clear input, an 8-bit input and an 8-bit output. Each requester submits an operand pair (x0, x1). The scheduler feeds the pair into the datapath on consecutive cycles, captures the result and returns it with the requester ID over a valid/ready response port. It sits between the requester blocks and the datapath instance and is the only driver of the datapath's clear and input.

## Interface
- `NUM_REQ`, 2: number of requesters, legal range 2..4.
- `ID_W`, 2: width of the requester ID; must satisfy 2**ID_W >= NUM_REQ.
- `clk`  in  1  the single clock; all logic on the rising edge.
- `clear`  in  1  reset, synchronous and active-low (0 = reset).
- `req_valid`  in  NUM_REQ  per-requester request valid.
- `req_ready`  out  NUM_REQ  per-requester accept, one-hot or zero.
- `req_data`  in  16*NUM_REQ  slice i is {x1[15:8], x0[7:0]} for requester i.
- `rsp_valid`  out  1  result available.
- `rsp_ready`  in  1  consumer accepts the result.
- `rsp_id`  out  ID_W  index of the requester that owns the result.
- `rsp_data`  out  8  result.
- `dp_clear`  out  1  datapath clear, active-high.
- `dp_input`  out  8  datapath input.
- `dp_output`  in  8  datapath output, combinational from the datapath registers.
- `mismatch`  out  1  sticky self-check error flag.

## Operation
- The datapath behaves as follows:
  - While its clear is high, its input is forced to 0x03 and its second register loads 0x55.
  - Otherwise, after the pair x0, x1 is fed on consecutive cycles, its output on the following cycle equals x1 ^ x0 ^ ((x1 + 0x22) mod 256).
- FSM states and transitions:
  - IDLE: `dp_clear`=1, `dp_input`=0x00. If any `req_valid` is high, grant the winner by round-robin, pulse `req_ready[winner]` for that cycle, latch x0, x1 and the ID, and go to FEED0.
  - FEED0: `dp_clear`=0, `dp_input`=x0; go to FEED1.
  - FEED1: `dp_clear`=0, `dp_input`=x1; go to CAPT.
  - CAPT: `dp_clear`=0, `dp_input`=x1; register `dp_output` into `rsp_data`; go to RESP.
  - RESP: `rsp_valid`=1 and `dp_clear`=1. Hold `rsp_data` and `rsp_id` stable until `rsp_ready`=1, then go to IDLE.
- Arbitration:
  - A pointer starts at 0.
  - The winner is the first requester with `req_valid` high, searching from the pointer upward with wrap-around.
  - After a grant to requester i, the pointer becomes (i+1) mod NUM_REQ.
  - Requests that arrive outside IDLE wait; `req_ready` is 0 in every state except IDLE.
  - Requesters hold `req_valid` and `req_data` until they see `req_ready`.
- Arithmetic: all sums are 8-bit with the carry discarded, e.g. 0xF0 + 0x22 = 0x12.
- Reset (`clear`=0):
  - State goes to IDLE and the pointer to 0.
  - `rsp_valid`=0, `rsp_data`=0x00, `rsp_id`=0, `req_ready`=0, `dp_clear`=1, `dp_input`=0x00, `mismatch`=0.
  - A transaction in flight when reset is asserted is dropped, and no response is issued for it.

## Timing
- Accept to `rsp_valid`: 4 cycles. Accept at edge t; FEED0 at t+1, FEED1 at t+2, CAPT at t+3, `rsp_valid` high from t+4.
- Minimum spacing between accepts is 5 cycles (IDLE, FEED0, FEED1, CAPT, RESP). It grows by one cycle for each cycle `rsp_ready` is held low.
- If `rsp_ready`=1 in the first RESP cycle, the next accept can occur in the IDLE cycle immediately after.
- `req_ready` is registered-state-decoded, asserted only in IDLE, and combinational on `req_valid` and the pointer.

## Configuration
- Macro: `Q3_SCHED_SELFCHECK_EN`.
- Defined:
  - An internal model computes x1 ^ x0 ^ (x1 + 0x22) during CAPT and compares it with `dp_output`.
  - Any difference sets `mismatch`, which stays high until reset.
- Undefined: `mismatch` is tied to 0 and no comparator logic is built.
- The port list is the same in both builds.

## Structure
- Package `q3_sched_pkg` holds:
  - the state enum (IDLE, FEED0, FEED1, CAPT, RESP);
  - `Q3_ADD_CONST` = 8'h22;
  - `Q3_CLR_IN` = 8'h03 and `Q3_CLR_R2` = 8'h55, the datapath clear values, used by the bench model;
  - the result function shared by the self-check and the bench.
- Sub-module `q3_rr_arbiter` contains the round-robin pointer and the winner/one-hot grant logic. It is parameterised by NUM_REQ and has the same `clk` and `clear` ports.

## Test plan
- Single request: requester 0 sends x0=0x10, x1=0x01 → `rsp_valid` 4 cycles after accept with `rsp_data`=0x32 and `rsp_id`=0.
- Wrap-around: requester 1 sends x0=0x00, x1=0xF0 → `rsp_data`=0xE2; with x0=0x00, x1=0x00 → `rsp_data`=0x22.
- Contention: both requesters hold `req_valid` continuously → grants alternate 0,1,0,1, each result tagged with the correct `rsp_id`, and accepts are exactly 5 cycles apart.
- Back-pressure: `rsp_ready` held low for 3 cycles in RESP → `rsp_data` and `rsp_id` stay stable, no new `req_ready`, and the next accept is delayed 3 cycles.
- Reset mid-operation: `clear`=0 during FEED1 → the next cycle is IDLE with `rsp_valid`=0 and `dp_clear`=1. A fresh request then completes normally, and the grant goes to requester 0 first.
- With `Q3_SCHED_SELFCHECK_EN` defined: force `dp_output` to the wrong value in CAPT → `mismatch`=1 from the next cycle and it stays set until `clear`=0.

Source files
------------

// File: rtl/q3_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : q3_sched_pkg
// Description : Shared types, constants and the reference result function
//               for the q3_sched round-robin datapath scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package q3_sched_pkg;

  // Scheduler FSM states
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FEED0 = 3'd1,
    FEED1 = 3'd2,
    CAPT  = 3'd3,
    RESP  = 3'd4
  } q3_state_e;

  // Constant added to x1 inside the datapath
  localparam logic [7:0] Q3_ADD_CONST = 8'h22;
  // Values the datapath loads while its clear is high
  localparam logic [7:0] Q3_CLR_IN    = 8'h03;
  localparam logic [7:0] Q3_CLR_R2    = 8'h55;

  // Expected datapath result for an operand pair (8-bit, carry dropped)
  function automatic logic [7:0] q3_result(input logic [7:0] x0, input logic [7:0] x1);
    logic [7:0] sum;
    sum = x1 + Q3_ADD_CONST;
    return x1 ^ x0 ^ sum;
  endfunction

endpackage
`default_nettype wire

// File: rtl/q3_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : q3_rr_arbiter
// Description : Round-robin arbiter. Picks the first valid requester at or
//               above the pointer (with wrap-around) and moves the pointer
//               past the winner when the grant is consumed.
// Revision    : 1.0 - initial release
// ============================================================================
module q3_rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 2
) (
  input  logic               clk,
  input  logic               clear,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id,
  output logic               any_req
);

  logic [ID_W-1:0] ptr_q;
  logic [ID_W-1:0] ptr_d;

  // Winner search: distance k from the pointer, first valid requester wins.
  // Both loop indices are constants after unrolling, so every select is static.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    any_req  = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!any_req && req[i] &&
            ((int'(ptr_q) + k == i) || (int'(ptr_q) + k == i + NUM_REQ))) begin
          any_req  = 1'b1;
          grant[i] = 1'b1;
          grant_id = ID_W'(i);
        end
      end
    end
  end

  // Pointer update: one past the granted requester, wrapping at NUM_REQ
  always_comb begin
    ptr_d = ptr_q;
    if (advance) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant[i]) begin
          ptr_d = (i == NUM_REQ - 1) ? '0 : ID_W'(i + 1);
        end
      end
    end
  end

  // Pointer register
  always_ff @(posedge clk) begin
    if (!clear) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/q3_sched.sv
`default_nettype none
// ============================================================================
// Module      : q3_sched
// Description : Round-robin scheduler sharing one 8-bit XOR/add datapath
//               among NUM_REQ requesters. Feeds x0 then x1, captures the
//               result and returns it with the owner ID on a valid/ready port.
//               Optional feature macro: Q3_SCHED_SELFCHECK_EN builds a
//               comparator that flags a wrong datapath result on `mismatch`.
// Revision    : 1.0 - initial release
// ============================================================================
module q3_sched
  import q3_sched_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 2
) (
  input  logic                  clk,
  input  logic                  clear,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [16*NUM_REQ-1:0] req_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [7:0]            rsp_data,
  output logic                  dp_clear,
  output logic [7:0]            dp_input,
  input  logic [7:0]            dp_output,
  output logic                  mismatch
);

  q3_state_e       state_q, state_d;
  logic [7:0]      x0_q, x0_d;
  logic [7:0]      x1_q, x1_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [7:0]      rsp_data_q, rsp_data_d;

  logic [NUM_REQ-1:0] arb_grant;
  logic [ID_W-1:0]    arb_id;
  logic               arb_any;
  logic               accept;
  logic [15:0]        win_data;

  // A grant is only consumed in IDLE and never while reset is held
  assign accept = clear && (state_q == IDLE) && arb_any;

  q3_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .clk      (clk),
    .clear    (clear),
    .req      (req_valid),
    .advance  (accept),
    .grant    (arb_grant),
    .grant_id (arb_id),
    .any_req  (arb_any)
  );

  // Operand pair of the current winner
  always_comb begin
    win_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_grant[i]) begin
        win_data = req_data[16*i +: 16];
      end
    end
  end

  // Next-state and operand/result capture
  always_comb begin
    state_d    = state_q;
    x0_d       = x0_q;
    x1_d       = x1_q;
    id_d       = id_q;
    rsp_data_d = rsp_data_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = FEED0;
          x0_d    = win_data[7:0];
          x1_d    = win_data[15:8];
          id_d    = arb_id;
        end
      end
      FEED0: state_d = FEED1;
      FEED1: state_d = CAPT;
      CAPT: begin
        rsp_data_d = dp_output;
        state_d    = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State-decoded outputs; reset forces the idle view immediately
  always_comb begin
    req_ready = '0;
    rsp_valid = 1'b0;
    dp_clear  = 1'b1;
    dp_input  = 8'h00;
    if (clear) begin
      case (state_q)
        IDLE: begin
          req_ready = arb_grant;
        end
        FEED0: begin
          dp_clear = 1'b0;
          dp_input = x0_q;
        end
        FEED1, CAPT: begin
          dp_clear = 1'b0;
          dp_input = x1_q;
        end
        RESP: begin
          rsp_valid = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign rsp_data = rsp_data_q;
  assign rsp_id   = id_q;

  // State and data registers
  always_ff @(posedge clk) begin
    if (!clear) begin
      state_q    <= IDLE;
      x0_q       <= 8'h00;
      x1_q       <= 8'h00;
      id_q       <= '0;
      rsp_data_q <= 8'h00;
    end else begin
      state_q    <= state_d;
      x0_q       <= x0_d;
      x1_q       <= x1_d;
      id_q       <= id_d;
      rsp_data_q <= rsp_data_d;
    end
  end

`ifdef Q3_SCHED_SELFCHECK_EN
  logic mismatch_q, mismatch_d;

  // Sticky compare of the captured result against the reference model
  always_comb begin
    mismatch_d = mismatch_q;
    if ((state_q == CAPT) && (dp_output != q3_result(x0_q, x1_q))) begin
      mismatch_d = 1'b1;
    end
  end

  // Mismatch flag register, cleared only by reset
  always_ff @(posedge clk) begin
    if (!clear) begin
      mismatch_q <= 1'b0;
    end else begin
      mismatch_q <= mismatch_d;
    end
  end

  assign mismatch = mismatch_q;
`else
  assign mismatch = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_q3_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_q3_sched
// Description : Directed self-checking bench for q3_sched with a behavioural
//               model of the shared XOR/add datapath.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_q3_sched;
  import q3_sched_pkg::*;

`ifdef Q3_SCHED_SELFCHECK_EN
  localparam logic EXP_MM = 1'b1;
`else
  localparam logic EXP_MM = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        clear;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] req_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_data;
  logic        dp_clear;
  logic [7:0]  dp_input;
  logic [7:0]  dp_output;
  logic        mismatch;

  logic [7:0]  dp_r1;
  logic [7:0]  dp_r2;
  logic [7:0]  corrupt;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int         rq;
    logic [7:0] x0;
    logic [7:0] x1;
    logic [7:0] exp_d;
  } vec_t;
  vec_t vecs[6];

  always #5 clk = ~clk;

  q3_sched #(.NUM_REQ(2), .ID_W(2)) dut (
    .clk       (clk),
    .clear     (clear),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .dp_clear  (dp_clear),
    .dp_input  (dp_input),
    .dp_output (dp_output),
    .mismatch  (mismatch)
  );

  // Datapath model: two-stage shift, result from the last two inputs
  always_ff @(posedge clk) begin
    dp_r1 <= dp_clear ? Q3_CLR_IN : dp_input;
    dp_r2 <= dp_clear ? Q3_CLR_R2 : dp_r1;
  end
  assign dp_output = (dp_r2 ^ dp_r1 ^ 8'(dp_r1 + 8'h22)) ^ corrupt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [1:0] oh(input int rq);
    return (rq == 0) ? 2'b01 : 2'b10;
  endfunction

  task automatic set_req(input int rq, input logic [7:0] x0, input logic [7:0] x1);
    if (rq == 0) req_data[15:0] = {x1, x0};
    else         req_data[31:16] = {x1, x0};
    req_valid = req_valid | oh(rq);
  endtask

  task automatic do_reset();
    clear = 1'b0;
    @(negedge clk);
    clear = 1'b1;
  endtask

  // One transaction with full latency checks; starts and ends at a negedge in IDLE
  task automatic run_txn(input int rq, input logic [7:0] x0, input logic [7:0] x1,
                         input logic [7:0] exp_d);
    bit ok;
    int cnt;
    ok  = 1'b0;
    cnt = 0;
    req_valid = 2'b00;
    set_req(rq, x0, x1);
    rsp_ready = 1'b1;
    #1;
    while (!ok && cnt < 20) begin
      if (req_ready == oh(rq)) ok = 1'b1;
      else begin
        @(negedge clk);
        cnt++;
      end
    end
    check("accept", 32'(ok), 32'd1);
    @(negedge clk);
    req_valid = 2'b00;
    check("feed0_clear", 32'(dp_clear), 32'd0);
    check("feed0_input", 32'(dp_input), 32'(x0));
    @(negedge clk);
    check("feed1_input", 32'(dp_input), 32'(x1));
    check("busy_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    check("capt_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    check("rsp_valid", 32'(rsp_valid), 32'd1);
    check("rsp_data", 32'(rsp_data), 32'(exp_d));
    check("rsp_id", 32'(rsp_id), 32'(rq));
    @(negedge clk);
    check("rsp_done", 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int g, r, last;
    vecs[0] = '{0, 8'h10, 8'h01, 8'h32};
    vecs[1] = '{1, 8'h00, 8'hF0, 8'hE2};
    vecs[2] = '{1, 8'h00, 8'h00, 8'h22};
    vecs[3] = '{0, 8'hFF, 8'hFF, 8'h21};
    vecs[4] = '{1, 8'hA5, 8'h5A, 8'h83};
    vecs[5] = '{0, 8'h00, 8'hDE, 8'hDE};

    clear     = 1'b0;
    req_valid = 2'b11;
    req_data  = 32'h0;
    rsp_ready = 1'b1;
    corrupt   = 8'h00;

    // Reset state, with requests pending that must not be granted
    repeat (2) @(negedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    check("rst_rsp_id", 32'(rsp_id), 32'd0);
    check("rst_dp_clear", 32'(dp_clear), 32'd1);
    check("rst_dp_input", 32'(dp_input), 32'd0);
    check("rst_mismatch", 32'(mismatch), 32'd0);
    req_valid = 2'b00;
    clear     = 1'b1;
    @(negedge clk);

    // Table-driven single transactions
    for (int v = 0; v < 6; v++) begin
      run_txn(vecs[v].rq, vecs[v].x0, vecs[v].x1, vecs[v].exp_d);
    end

    // Contention: both requesters always valid, grants alternate from 0
    do_reset();
    req_valid = 2'b00;
    set_req(0, 8'h10, 8'h01);
    set_req(1, 8'h00, 8'hF0);
    rsp_ready = 1'b1;
    #1;
    g = 0; r = 0; last = 0;
    for (int cyc = 0; cyc < 60 && r < 4; cyc++) begin
      if (req_ready != 2'b00) begin
        check("cont_grant", 32'(req_ready), 32'(oh(g % 2)));
        if (g > 0) check("cont_spacing", 32'(cyc - last), 32'd5);
        last = cyc;
        g++;
      end
      if (rsp_valid) begin
        check("cont_id", 32'(rsp_id), 32'(r % 2));
        check("cont_data", 32'(rsp_data), (r % 2 == 0) ? 32'h32 : 32'hE2);
        r++;
      end
      if (r == 4) req_valid = 2'b00;
      @(negedge clk);
    end
    check("cont_grants", 32'(g), 32'd4);
    check("cont_rsps", 32'(r), 32'd4);

    // Back-pressure: rsp_ready low for three RESP cycles
    req_valid = 2'b00;
    set_req(0, 8'h33, 8'h44);
    rsp_ready = 1'b0;
    #1;
    check("bp_accept", 32'(req_ready), 32'b01);
    @(negedge clk);
    req_valid = 2'b00;
    set_req(1, 8'h34, 8'h12);
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check("bp_valid", 32'(rsp_valid), 32'd1);
      check("bp_data", 32'(rsp_data), 32'h11);
      check("bp_id", 32'(rsp_id), 32'd0);
      check("bp_no_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    check("bp_data_last", 32'(rsp_data), 32'h11);
    rsp_ready = 1'b1;
    #1;
    check("bp_no_ready_last", 32'(req_ready), 32'd0);
    @(negedge clk);
    check("bp_accept_delay", 32'(req_ready), 32'b10);
    @(negedge clk);
    req_valid = 2'b00;
    repeat (3) @(negedge clk);
    check("bp2_valid", 32'(rsp_valid), 32'd1);
    check("bp2_data", 32'(rsp_data), 32'h12);
    check("bp2_id", 32'(rsp_id), 32'd1);
    @(negedge clk);

    // Reset during FEED1 drops the transaction and restarts the pointer
    req_valid = 2'b00;
    set_req(0, 8'h10, 8'h01);
    #1;
    check("rm_accept", 32'(req_ready), 32'b01);
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    clear = 1'b0;
    @(negedge clk);
    clear = 1'b1;
    set_req(0, 8'hFF, 8'hFF);
    set_req(1, 8'h10, 8'h01);
    #1;
    check("rm_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rm_dp_clear", 32'(dp_clear), 32'd1);
    check("rm_dp_input", 32'(dp_input), 32'd0);
    check("rm_grant0", 32'(req_ready), 32'b01);
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    @(negedge clk);
    check("rm_no_stale", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    check("rm_valid", 32'(rsp_valid), 32'd1);
    check("rm_data", 32'(rsp_data), 32'h21);
    check("rm_id", 32'(rsp_id), 32'd0);
    @(negedge clk);

    // Corrupted datapath result: flag only exists in the self-check build
    check("mm_clean", 32'(mismatch), 32'd0);
    corrupt = 8'h01;
    run_txn(1, 8'h00, 8'h00, 8'h23);
    corrupt = 8'h00;
    check("mm_set", 32'(mismatch), 32'(EXP_MM));
    run_txn(0, 8'h10, 8'h01, 8'h32);
    check("mm_sticky", 32'(mismatch), 32'(EXP_MM));
    do_reset();
    #1;
    check("mm_cleared", 32'(mismatch), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
